// File: rtl/pll_lock_sequencer.sv
// rtl/pll_lock_sequencer.sv - PLL reset/lock sequencer gating sys_reset until lock is stable
// Optional RUN-state lock-loss monitor: define PLL_SEQ_LOCK_MONITOR_EN.
module pll_lock_sequencer #(
    parameter int unsigned RESET_CYCLES  = 16,
    parameter int unsigned LOCK_TIMEOUT  = 50000,
    parameter int unsigned STABLE_CYCLES = 256,
    parameter int unsigned MAX_RETRIES   = 3
) (
    input  logic       clock_in,
    input  logic       reset,
    input  logic       pll_lock,
    input  logic       restart,
    output logic       pll_resetb,
    output logic       sys_reset,
    output logic       ready,
    output logic       fault,
    output logic [3:0] retry_count
);

    typedef enum logic [2:0] {
        S_RESET_PLL = 3'd0,
        S_WAIT_LOCK = 3'd1,
        S_STABLE    = 3'd2,
        S_RUN       = 3'd3,
        S_FAULT     = 3'd4
`ifdef PLL_SEQ_LOCK_MONITOR_EN
        , S_LOCK_LOST = 3'd5
`endif
    } state_t;

    localparam logic [15:0] RESET_LAST   = 16'(RESET_CYCLES - 1);
    localparam logic [15:0] TIMEOUT_LAST = 16'(LOCK_TIMEOUT - 1);
    // The lock-detect cycle in WAIT_LOCK is the first of the STABLE_CYCLES run.
    localparam logic [15:0] STABLE_LAST  = 16'(STABLE_CYCLES - 2);
    localparam logic [3:0]  MAX_R        = 4'(MAX_RETRIES);

    state_t      state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic [3:0]  retry_q, retry_d;
    logic        sync1_q, lock_s_q;
    logic        pll_resetb_q, pll_resetb_d;
    logic        sys_reset_q, sys_reset_d;
    logic        ready_q, ready_d;
    logic        fault_q, fault_d;
    logic        retry_event;

    always_ff @(posedge clock_in or posedge reset) begin
        if (reset) begin
            state_q      <= S_RESET_PLL;
            cnt_q        <= 16'd0;
            retry_q      <= 4'd0;
            sync1_q      <= 1'b0;
            lock_s_q     <= 1'b0;
            pll_resetb_q <= 1'b0;
            sys_reset_q  <= 1'b1;
            ready_q      <= 1'b0;
            fault_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            retry_q      <= retry_d;
            sync1_q      <= pll_lock;
            lock_s_q     <= sync1_q;
            pll_resetb_q <= pll_resetb_d;
            sys_reset_q  <= sys_reset_d;
            ready_q      <= ready_d;
            fault_q      <= fault_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        retry_d     = retry_q;
        retry_event = 1'b0;
        case (state_q)
            S_RESET_PLL: if (cnt_q == RESET_LAST) state_d = S_WAIT_LOCK;
            S_WAIT_LOCK: begin
                if (lock_s_q)
                    state_d = (STABLE_CYCLES == 1) ? S_RUN : S_STABLE;
                else if (cnt_q == TIMEOUT_LAST)
                    retry_event = 1'b1;
            end
            S_STABLE: begin
                if (!lock_s_q)
                    state_d = S_WAIT_LOCK;
                else if (cnt_q == STABLE_LAST)
                    state_d = S_RUN;
            end
            S_RUN: begin
`ifdef PLL_SEQ_LOCK_MONITOR_EN
                if (!lock_s_q) state_d = S_LOCK_LOST;
`endif
            end
`ifdef PLL_SEQ_LOCK_MONITOR_EN
            S_LOCK_LOST: retry_event = 1'b1;
`endif
            S_FAULT: state_d = S_FAULT;
            default: state_d = S_RESET_PLL;
        endcase

        if (retry_event) begin
            if (retry_q < MAX_R) begin
                state_d = S_RESET_PLL;
                retry_d = retry_q + 4'd1;
            end else begin
                state_d = S_FAULT;
            end
        end

        // Restart outranks any timeout, lock or lock-loss event in the same cycle.
        if (restart) begin
            state_d = S_RESET_PLL;
            retry_d = 4'd0;
        end

        if (restart || (state_d != state_q))
            cnt_d = 16'd0;
        else if (cnt_q == 16'hFFFF)
            cnt_d = cnt_q;
        else
            cnt_d = cnt_q + 16'd1;

        pll_resetb_d = !((state_d == S_RESET_PLL) || (state_d == S_FAULT));
        sys_reset_d  = (state_d != S_RUN);
        ready_d      = (state_d == S_RUN);
        fault_d      = (state_d == S_FAULT);
    end

    assign pll_resetb  = pll_resetb_q;
    assign sys_reset   = sys_reset_q;
    assign ready       = ready_q;
    assign fault       = fault_q;
    assign retry_count = retry_q;

endmodule

// File: tb/tb_pll_lock_sequencer.sv
// tb/tb_pll_lock_sequencer.sv - directed self-checking bench for pll_lock_sequencer
module tb_pll_lock_sequencer;

    logic       clk = 1'b0;
    logic       reset;
    logic       pll_lock;
    logic       restart;
    logic       pll_resetb;
    logic       sys_reset;
    logic       ready;
    logic       fault;
    logic [3:0] retry_count;

    int n_cmp = 0;
    int n_bad = 0;

    pll_lock_sequencer #(
        .RESET_CYCLES(4), .LOCK_TIMEOUT(100), .STABLE_CYCLES(8), .MAX_RETRIES(2)
    ) dut (
        .clock_in(clk), .reset(reset), .pll_lock(pll_lock), .restart(restart),
        .pll_resetb(pll_resetb), .sys_reset(sys_reset), .ready(ready),
        .fault(fault), .retry_count(retry_count)
    );

    always #5 clk = ~clk;

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse_restart();
        restart = 1'b1;
        step(1);
        restart = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; pll_lock = 1'b0; restart = 1'b0;
        step(2);
        n_cmp++; if (pll_resetb !== 1'b0) begin n_bad++; $display("FAIL reset_pll_resetb got %b want 0", pll_resetb); end
        n_cmp++; if (sys_reset !== 1'b1) begin n_bad++; $display("FAIL reset_sys_reset got %b want 1", sys_reset); end
        n_cmp++; if (ready !== 1'b0 || fault !== 1'b0) begin n_bad++; $display("FAIL reset_ready_fault got %b%b want 00", ready, fault); end
        n_cmp++; if (retry_count !== 4'd0) begin n_bad++; $display("FAIL reset_retry got %0d want 0", retry_count); end
        reset = 1'b0;
    endtask

    task automatic test_nominal();
        int n;
        n = 0;
        while (pll_resetb !== 1'b1 && n < 20) begin step(1); n++; end
        n_cmp++; if (n !== 4) begin n_bad++; $display("FAIL nominal_reset_len got %0d want 4", n); end
        step(10);
        pll_lock = 1'b1;
        n = 0;
        while (ready !== 1'b1 && n < 50) begin step(1); n++; end
        n_cmp++; if (n !== 10) begin n_bad++; $display("FAIL nominal_lock_to_ready got %0d want 10", n); end
        n_cmp++; if (sys_reset !== 1'b0 || pll_resetb !== 1'b1) begin n_bad++; $display("FAIL nominal_run_outputs got sys_reset=%b pll_resetb=%b want 0 1", sys_reset, pll_resetb); end
        n_cmp++; if (retry_count !== 4'd0) begin n_bad++; $display("FAIL nominal_retry got %0d want 0", retry_count); end
    endtask

    task automatic test_lock_loss();
        int n;
        pll_lock = 1'b0;
`ifdef PLL_SEQ_LOCK_MONITOR_EN
        n = 0;
        while (sys_reset !== 1'b1 && n < 10) begin step(1); n++; end
        n_cmp++; if (n !== 3) begin n_bad++; $display("FAIL lockloss_sys_reset_delay got %0d want 3", n); end
        n_cmp++; if (ready !== 1'b0) begin n_bad++; $display("FAIL lockloss_ready got %b want 0", ready); end
        step(1);
        n_cmp++; if (retry_count !== 4'd1 || pll_resetb !== 1'b0) begin n_bad++; $display("FAIL lockloss_restart got retry=%0d pll_resetb=%b want 1 0", retry_count, pll_resetb); end
        pll_lock = 1'b1;
        n = 0;
        while (ready !== 1'b1 && n < 100) begin step(1); n++; end
        n_cmp++; if (ready !== 1'b1 || retry_count !== 4'd1) begin n_bad++; $display("FAIL lockloss_regain got ready=%b retry=%0d want 1 1", ready, retry_count); end
`else
        step(20);
        n_cmp++; if (ready !== 1'b1 || sys_reset !== 1'b0) begin n_bad++; $display("FAIL nomonitor_run got ready=%b sys_reset=%b want 1 0", ready, sys_reset); end
        pll_lock = 1'b1;
        n = 0;
`endif
    endtask

    task automatic test_glitch();
        int n;
        pulse_restart();
        n_cmp++; if (retry_count !== 4'd0 || pll_resetb !== 1'b0) begin n_bad++; $display("FAIL glitch_restart got retry=%0d pll_resetb=%b want 0 0", retry_count, pll_resetb); end
        n = 0;
        while (pll_resetb !== 1'b1 && n < 20) begin step(1); n++; end
        step(2);
        pll_lock = 1'b0;
        step(1);
        pll_lock = 1'b1;
        n = 0;
        while (ready !== 1'b1 && n < 50) begin step(1); n++; end
        n_cmp++; if (n !== 10) begin n_bad++; $display("FAIL glitch_recovery_to_ready got %0d want 10", n); end
        n_cmp++; if (retry_count !== 4'd0 || fault !== 1'b0) begin n_bad++; $display("FAIL glitch_retry got retry=%0d fault=%b want 0 0", retry_count, fault); end
    endtask

    task automatic test_timeout_chain();
        int n;
        pll_lock = 1'b0;
        pulse_restart();
        for (int i = 0; i < 3; i++) begin
            n = 0;
            while (pll_resetb !== 1'b1 && n < 20) begin step(1); n++; end
            n_cmp++; if (retry_count !== 4'(i)) begin n_bad++; $display("FAIL timeout_retry_%0d got %0d want %0d", i, retry_count, i); end
            n = 0;
            while (pll_resetb === 1'b1 && n < 200) begin step(1); n++; end
            n_cmp++; if (n !== 100) begin n_bad++; $display("FAIL timeout_window_%0d got %0d want 100", i, n); end
        end
        n_cmp++; if (fault !== 1'b1 || pll_resetb !== 1'b0 || retry_count !== 4'd2) begin n_bad++; $display("FAIL timeout_fault got fault=%b pll_resetb=%b retry=%0d want 1 0 2", fault, pll_resetb, retry_count); end
        step(1000);
        n_cmp++; if (fault !== 1'b1 || pll_resetb !== 1'b0 || ready !== 1'b0) begin n_bad++; $display("FAIL fault_hold got fault=%b pll_resetb=%b ready=%b want 1 0 0", fault, pll_resetb, ready); end
    endtask

    task automatic test_restart_collisions();
        int n;
        pulse_restart();
        n_cmp++; if (fault !== 1'b0 || retry_count !== 4'd0 || pll_resetb !== 1'b0 || sys_reset !== 1'b1) begin n_bad++; $display("FAIL restart_from_fault got fault=%b retry=%0d pll_resetb=%b sys_reset=%b want 0 0 0 1", fault, retry_count, pll_resetb, sys_reset); end
        for (int i = 0; i < 2; i++) begin
            n = 0;
            while (pll_resetb !== 1'b1 && n < 20) begin step(1); n++; end
            n = 0;
            while (pll_resetb === 1'b1 && n < 200) begin step(1); n++; end
        end
        n = 0;
        while (pll_resetb !== 1'b1 && n < 20) begin step(1); n++; end
        n_cmp++; if (retry_count !== 4'd2) begin n_bad++; $display("FAIL collision_pre_retry got %0d want 2", retry_count); end
        step(99);
        pulse_restart();
        n_cmp++; if (retry_count !== 4'd0 || fault !== 1'b0 || pll_resetb !== 1'b0) begin n_bad++; $display("FAIL collision_restart got retry=%0d fault=%b pll_resetb=%b want 0 0 0", retry_count, fault, pll_resetb); end
        n = 0;
        while (pll_resetb !== 1'b1 && n < 20) begin step(1); n++; end
        n_cmp++; if (n !== 4) begin n_bad++; $display("FAIL collision_reset_len got %0d want 4", n); end
    endtask

    task automatic test_async_reset();
        int n;
        pll_lock = 1'b1;
        n = 0;
        while (ready !== 1'b1 && n < 100) begin step(1); n++; end
        n_cmp++; if (ready !== 1'b1) begin n_bad++; $display("FAIL async_pre_run got ready=%b want 1", ready); end
        #3;
        reset = 1'b1;
        #1;
        n_cmp++; if (sys_reset !== 1'b1 || pll_resetb !== 1'b0 || ready !== 1'b0) begin n_bad++; $display("FAIL async_reset got sys_reset=%b pll_resetb=%b ready=%b want 1 0 0", sys_reset, pll_resetb, ready); end
        step(2);
        reset = 1'b0;
        n = 0;
        while (pll_resetb !== 1'b1 && n < 20) begin step(1); n++; end
        n_cmp++; if (n !== 4) begin n_bad++; $display("FAIL async_resequence_len got %0d want 4", n); end
    endtask

    initial begin
        test_reset();
        test_nominal();
        test_lock_loss();
        test_glitch();
        test_timeout_chain();
        test_restart_collisions();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
